// File: rtl/uart_rx_oversampled_if.sv
// Receive-side word handshake between the oversampled UART RX and its consumer.
// The receiver drives the word and its error flags; the consumer drives rx_ready.
interface uart_rx_oversampled_if #(
  parameter int WORD_LENGHT = 8
);
  logic [WORD_LENGHT-1:0] RX_out;
  logic                   rx_valid;
  logic                   rx_ready;
  logic                   parity_error;
  logic                   framing_error;
  logic                   overrun;

  modport master (
    output RX_out,
    output rx_valid,
    output parity_error,
    output framing_error,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  RX_out,
    input  rx_valid,
    input  parity_error,
    input  framing_error,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: start qualification, mid-bit sampling,
// optional parity, 1/2 stop bits, valid/ready output register.
module uart_rx_oversampled #(
  parameter int WORD_LENGHT = 8,
  parameter int FREQUENCY   = 50000000,
  parameter int BAUDRATE    = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic RX_in,
  output logic busy,
  uart_rx_oversampled_if.master rx
);
  localparam int DIV = FREQUENCY / (BAUDRATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] SC_HALF  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BC_DATA  = 4'(WORD_LENGHT - 1);
  localparam logic [3:0]    BC_STOP  = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD  = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t state, state_n;
  logic [DW-1:0] div_cnt;
  logic tick;
  logic rx_meta, rxs;
  logic [SW-1:0] sc, sc_n;
  logic [3:0] bc, bc_n;
  logic [WORD_LENGHT-1:0] sh, sh_n;
  logic perr, perr_n;
  logic ferr, ferr_n;
  logic done;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      rx_meta <= RX_in;
      rxs     <= rx_meta;
    end
  end

  always_comb begin
    state_n = state;
    sc_n    = sc;
    bc_n    = bc;
    sh_n    = sh;
    perr_n  = perr;
    ferr_n  = ferr;
    done    = 1'b0;
    if (tick) begin
      unique case (state)
        S_IDLE: begin
          if (!rxs) begin
            state_n = S_START;
            sc_n    = '0;
          end
        end
        S_START: begin
          if (sc == SC_HALF) begin
            sc_n    = '0;
            bc_n    = '0;
            perr_n  = 1'b0;
            ferr_n  = 1'b0;
            state_n = rxs ? S_IDLE : S_DATA;
          end else begin
            sc_n = sc + 1'b1;
          end
        end
        S_DATA: begin
          if (sc == SC_LAST) begin
            sc_n = '0;
            sh_n = {rxs, sh[WORD_LENGHT-1:1]};
            bc_n = bc + 1'b1;
            if (bc == BC_DATA) begin
              bc_n    = '0;
              state_n = (PARITY != 0) ? S_PARITY : S_STOP;
            end
          end else begin
            sc_n = sc + 1'b1;
          end
        end
        S_PARITY: begin
          if (sc == SC_LAST) begin
            sc_n    = '0;
            perr_n  = (^sh) ^ rxs ^ PAR_ODD;
            state_n = S_STOP;
          end else begin
            sc_n = sc + 1'b1;
          end
        end
        S_STOP: begin
          if (sc == SC_LAST) begin
            sc_n = '0;
            if (!rxs) ferr_n = 1'b1;
            if (bc == BC_STOP) begin
              done    = 1'b1;
              state_n = rxs ? S_IDLE : S_BREAK;
            end else begin
              bc_n = bc + 1'b1;
            end
          end else begin
            sc_n = sc + 1'b1;
          end
        end
        S_BREAK: begin
          if (rxs) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      sc    <= '0;
      bc    <= '0;
      sh    <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      sc    <= sc_n;
      bc    <= bc_n;
      sh    <= sh_n;
      perr  <= perr_n;
      ferr  <= ferr_n;
      busy  <= (state_n != S_IDLE);
    end
  end

  // A completed frame may replace the held word only if it is leaving now.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx.RX_out        <= '0;
      rx.rx_valid      <= 1'b0;
      rx.parity_error  <= 1'b0;
      rx.framing_error <= 1'b0;
      rx.overrun       <= 1'b0;
    end else if (done) begin
      if (!rx.rx_valid || rx.rx_ready) begin
        rx.RX_out        <= sh_n;
        rx.parity_error  <= perr_n;
        rx.framing_error <= ferr_n;
        rx.rx_valid      <= 1'b1;
        rx.overrun       <= 1'b0;
      end else begin
        rx.overrun <= 1'b1;
      end
    end else if (rx.rx_valid && rx.rx_ready) begin
      rx.rx_valid      <= 1'b0;
      rx.overrun       <= 1'b0;
      rx.parity_error  <= 1'b0;
      rx.framing_error <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: 8N1 instance and 8E2 instance
// on scaled clock/baud (4 clk per tick, 8 ticks per bit).
module tb_uart_rx_oversampled;
  localparam int BT = 32;

  logic clk = 1'b0;
  logic rst;
  logic rx1, rx2;
  logic busy1, busy2;
  int checks = 0;
  int errors = 0;
  int hs1 = 0, hs2 = 0;
  logic [7:0] w1, w2;
  logic pe1, fe1, pe2, fe2;

  always #5 clk = ~clk;

  uart_rx_oversampled_if #(.WORD_LENGHT(8)) if1 ();
  uart_rx_oversampled_if #(.WORD_LENGHT(8)) if2 ();

  uart_rx_oversampled #(
    .WORD_LENGHT(8), .FREQUENCY(3200), .BAUDRATE(100),
    .OVERSAMPLE(8), .PARITY(0), .STOP_BITS(1)
  ) dut1 (
    .clk(clk), .rst(rst), .RX_in(rx1), .busy(busy1), .rx(if1.master)
  );

  uart_rx_oversampled #(
    .WORD_LENGHT(8), .FREQUENCY(3200), .BAUDRATE(100),
    .OVERSAMPLE(8), .PARITY(2), .STOP_BITS(2)
  ) dut2 (
    .clk(clk), .rst(rst), .RX_in(rx2), .busy(busy2), .rx(if2.master)
  );

  always @(negedge clk) begin
    if (if1.rx_valid === 1'b1 && if1.rx_ready === 1'b1) begin
      hs1++;
      w1  = if1.RX_out;
      pe1 = if1.parity_error;
      fe1 = if1.framing_error;
    end
    if (if2.rx_valid === 1'b1 && if2.rx_ready === 1'b1) begin
      hs2++;
      w2  = if2.RX_out;
      pe2 = if2.parity_error;
      fe2 = if2.framing_error;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 1) rx1 = bits[i];
      else rx2 = bits[i];
      step(BT);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rx1 = 1'b1;
    rx2 = 1'b1;
    if1.rx_ready = 1'b0;
    if2.rx_ready = 1'b0;
    step(3);
    checks++;
    if (if1.RX_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_out got %h exp 00", if1.RX_out);
    end
    checks++;
    if (if1.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b exp 0", if1.rx_valid);
    end
    checks++;
    if (if1.parity_error !== 1'b0 || if1.framing_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got pe=%b fe=%b exp 0 0",
               if1.parity_error, if1.framing_error);
    end
    checks++;
    if (if1.overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_overrun got %b exp 0", if1.overrun);
    end
    checks++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b %b exp 0 0", busy1, busy2);
    end
    checks++;
    if (if2.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid2 got %b exp 0", if2.rx_valid);
    end
    rst = 1'b1;
    step(4);
  endtask

  task automatic test_basic;
    int h;
    logic [15:0] f;
    if1.rx_ready = 1'b1;
    h = hs1;
    f = {6'b0, 1'b1, 8'hA5, 1'b0};
    send_raw(1, f, 5);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_mid got %b exp 1", busy1);
    end
    send_raw(1, f >> 5, 5);
    step(BT);
    checks++;
    if (hs1 - h !== 1) begin
      errors++;
      $display("FAIL basic_handshakes got %0d exp 1", hs1 - h);
    end
    checks++;
    if (w1 !== 8'hA5) begin
      errors++;
      $display("FAIL basic_word got %h exp a5", w1);
    end
    checks++;
    if (pe1 !== 1'b0 || fe1 !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags got pe=%b fe=%b exp 0 0", pe1, fe1);
    end
    checks++;
    if (busy1 !== 1'b0 || if1.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got busy=%b valid=%b exp 0 0",
               busy1, if1.rx_valid);
    end
  endtask

  task automatic test_parity;
    int h;
    if2.rx_ready = 1'b1;
    h = hs2;
    send_raw(2, {4'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0}, 12);
    step(BT);
    checks++;
    if (hs2 - h !== 1 || w2 !== 8'h3C) begin
      errors++;
      $display("FAIL parity_bad_word got n=%0d w=%h exp 1 3c", hs2 - h, w2);
    end
    checks++;
    if (pe2 !== 1'b1 || fe2 !== 1'b0) begin
      errors++;
      $display("FAIL parity_bad_flags got pe=%b fe=%b exp 1 0", pe2, fe2);
    end
    send_raw(2, {4'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0}, 12);
    step(BT);
    checks++;
    if (hs2 - h !== 2 || w2 !== 8'h3C) begin
      errors++;
      $display("FAIL parity_ok_word got n=%0d w=%h exp 2 3c", hs2 - h, w2);
    end
    checks++;
    if (pe2 !== 1'b0 || fe2 !== 1'b0) begin
      errors++;
      $display("FAIL parity_ok_flags got pe=%b fe=%b exp 0 0", pe2, fe2);
    end
    send_raw(2, {4'b0, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0}, 12);
    rx2 = 1'b1;
    step(2 * BT);
    checks++;
    if (hs2 - h !== 3 || w2 !== 8'hC3) begin
      errors++;
      $display("FAIL stop2_word got n=%0d w=%h exp 3 c3", hs2 - h, w2);
    end
    checks++;
    if (fe2 !== 1'b1 || pe2 !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL stop2_flags got fe=%b pe=%b busy=%b exp 1 0 0",
               fe2, pe2, busy2);
    end
  endtask

  task automatic test_framing;
    int h;
    h = hs1;
    send_raw(1, {6'b0, 1'b0, 8'h55, 1'b0}, 10);
    step(3 * BT);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL framing_busy_low got %b exp 1", busy1);
    end
    checks++;
    if (hs1 - h !== 1 || w1 !== 8'h55) begin
      errors++;
      $display("FAIL framing_word got n=%0d w=%h exp 1 55", hs1 - h, w1);
    end
    checks++;
    if (fe1 !== 1'b1 || pe1 !== 1'b0) begin
      errors++;
      $display("FAIL framing_flags got fe=%b pe=%b exp 1 0", fe1, pe1);
    end
    rx1 = 1'b1;
    step(2 * BT);
    checks++;
    if (busy1 !== 1'b0 || hs1 - h !== 1) begin
      errors++;
      $display("FAIL framing_release got busy=%b n=%0d exp 0 1",
               busy1, hs1 - h);
    end
  endtask

  task automatic test_glitch;
    int h;
    h = hs1;
    rx1 = 1'b0;
    step(8);
    rx1 = 1'b1;
    step(2 * BT);
    checks++;
    if (hs1 !== h || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL glitch_ignored got n=%0d busy=%b exp 0 0",
               hs1 - h, busy1);
    end
    send_raw(1, {6'b0, 1'b1, 8'h0F, 1'b0}, 10);
    step(BT);
    checks++;
    if (hs1 - h !== 1 || w1 !== 8'h0F || fe1 !== 1'b0) begin
      errors++;
      $display("FAIL glitch_next got n=%0d w=%h fe=%b exp 1 0f 0",
               hs1 - h, w1, fe1);
    end
  endtask

  task automatic test_back_to_back;
    int h;
    if1.rx_ready = 1'b0;
    h = hs1;
    send_raw(1, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
    send_raw(1, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
    step(BT);
    checks++;
    if (if1.rx_valid !== 1'b1 || if1.RX_out !== 8'h11) begin
      errors++;
      $display("FAIL b2b_held got v=%b w=%h exp 1 11",
               if1.rx_valid, if1.RX_out);
    end
    checks++;
    if (if1.overrun !== 1'b1 || hs1 !== h) begin
      errors++;
      $display("FAIL b2b_overrun got ov=%b n=%0d exp 1 0",
               if1.overrun, hs1 - h);
    end
    if1.rx_ready = 1'b1;
    step(1);
    checks++;
    if (if1.rx_valid !== 1'b0 || if1.overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got v=%b ov=%b exp 0 0",
               if1.rx_valid, if1.overrun);
    end
    checks++;
    if (hs1 - h !== 1 || w1 !== 8'h11) begin
      errors++;
      $display("FAIL b2b_taken got n=%0d w=%h exp 1 11", hs1 - h, w1);
    end
  endtask

  task automatic test_reset_mid;
    int h;
    h = hs1;
    send_raw(1, {11'b0, 4'b1111, 1'b0}, 5);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy_before got %b exp 1", busy1);
    end
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    checks++;
    if (if1.RX_out !== 8'h00 || if1.rx_valid !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs got w=%h v=%b busy=%b exp 00 0 0",
               if1.RX_out, if1.rx_valid, busy1);
    end
    checks++;
    if (if1.parity_error !== 1'b0 || if1.framing_error !== 1'b0 ||
        if1.overrun !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_flags got pe=%b fe=%b ov=%b exp 0 0 0",
               if1.parity_error, if1.framing_error, if1.overrun);
    end
    send_raw(1, {11'b0, 1'b1, 4'b1111}, 5);
    step(BT);
    checks++;
    if (hs1 !== h || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_partial got n=%0d busy=%b exp 0 0",
               hs1 - h, busy1);
    end
    send_raw(1, {6'b0, 1'b1, 8'h81, 1'b0}, 10);
    step(BT);
    checks++;
    if (hs1 - h !== 1 || w1 !== 8'h81) begin
      errors++;
      $display("FAIL rstmid_next got n=%0d w=%h exp 1 81", hs1 - h, w1);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_framing;
    test_glitch;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Parametrised UART receiver replacing the single-rate RX path: generates its own oversampling tick, qualifies the start bit, majority-free mid-bit samples each bit, checks optional parity and 1 or 2 stop bits, and delivers each word through a valid/ready output register with per-word error flags. Sits between the synchronised `RX_in` pad and any consumer (FIFO, register file, command decoder) in the UART top.

## Interface
- `WORD_LENGHT`, 8, data bits per frame (5–9)
- `FREQUENCY`, 50000000, `clk` frequency in Hz
- `BAUDRATE`, 9600, line bit rate
- `OVERSAMPLE`, 16, ticks per bit (even, ≥ 4)
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- `STOP_BITS`, 1, 1 or 2
- `clk`  input  1  system clock; one clock, all logic on rising edge
- `rst`  input  1  reset; synchronous and active-low
- `RX_in`  input  1  asynchronous serial line, idle high
- `rx_ready`  input  1  consumer accepts held word this cycle
- `RX_out`  output  WORD_LENGHT  received word, LSB = first data bit
- `rx_valid`  output  1  `RX_out` and flags hold an unaccepted word
- `parity_error`  output  1  parity mismatch on held word
- `framing_error`  output  1  a stop bit sampled low on held word
- `overrun`  output  1  ≥ 1 frame dropped while this word was held
- `busy`  output  1  FSM not in IDLE

## Operation
- Tick generator: counter 0..DIV-1, DIV = floor(FREQUENCY / (BAUDRATE·OVERSAMPLE)); one-cycle `tick` on wrap. Counter free-runs; reset clears it to 0.
- Two-flop synchroniser on `RX_in`, both flops reset to 1; FSM sees only the second flop (`rxs`).
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. Tick-count register `sc` (log2 OVERSAMPLE bits), bit counter `bc`.
- IDLE: on a tick with `rxs`=0 → START, `sc`=0.
- START: on the tick where `sc` = OVERSAMPLE/2−1 sample `rxs`; 1 → IDLE (glitch, no output); 0 → DATA, `sc`=0, `bc`=0.
- DATA: sample every OVERSAMPLE ticks (`sc` = OVERSAMPLE−1), shift in LSB first; after WORD_LENGHT samples → PARITY if PARITY≠0 else STOP.
- PARITY: one sample; error if XOR(data, bit) ≠ 1 for odd or ≠ 0 for even.
- STOP: STOP_BITS samples; any 0 sets framing error. On last stop sample: frame complete; → IDLE if that sample is 1, else → BREAK.
- BREAK: wait until a tick with `rxs`=1, then IDLE. No start detection in BREAK.
- Completion with `rx_valid`=0, or `rx_valid`=1 and `rx_ready`=1: load `RX_out`, `parity_error`, `framing_error`; `rx_valid`←1; `overrun`←0.
- Completion with `rx_valid`=1 and `rx_ready`=0: frame discarded, held word unchanged, `overrun`←1.
- `rx_ready`=1 with `rx_valid`=1 and no completion: `rx_valid`, `overrun`, error flags ←0 next cycle. `rx_ready` with `rx_valid`=0 is ignored.
- Frames with errors are still delivered; consumer decides.

## Timing
- Reset (`rst`=0 at rising edge): FSM IDLE; `RX_out`=0, `rx_valid`=0, `parity_error`=0, `framing_error`=0, `overrun`=0, `busy`=0; counters 0. Reset mid-frame abandons the frame; no partial word ever appears.
- Start edge recognised up to 2 clk (sync) + 1 tick late; all samples fall within ±1 tick of bit centre.
- Outputs registered: `rx_valid` rises 1 clk after the clock edge on which the final stop-bit sample is taken.
- Handshake: word transferred on any cycle with `rx_valid`=1 and `rx_ready`=1; consumer may hold `rx_ready` high permanently.
- FSM returns to IDLE at mid last stop bit so back-to-back frames are never missed.
- `busy` = registered (state ≠ IDLE).

## Test plan
- Defaults (DIV=325, bit = 5200 clk), `rx_ready`=1 after valid, send 8N1 0xA5 → `RX_out`=0xA5, `rx_valid` one handshake, all flags 0, `busy` low after mid-stop.
- PARITY=2, send 0x3C with parity bit 1 → `RX_out`=0x3C, `parity_error`=1; with bit 0 → `parity_error`=0.
- Send 0x55 with stop bit low, line low 3 further bit times → `framing_error`=1, `busy`=1 until line high, no second word.
- Low pulse 2000 clk on idle line → no `rx_valid`, FSM back to IDLE, next frame 0x0F received correctly.
- `rx_ready`=0, send 0x11 then 0x22 back-to-back → `RX_out`=0x11, `overrun`=1; assert `rx_ready` → `rx_valid`=0, `overrun`=0.
- Assert `rst`=0 for 1 clk mid data bits of 0xFF → all outputs 0; next frame 0x81 received as 0x81.
